// File: rtl/sub_deparser_pkg.sv
// Shared definitions for the sequential deparser field extractor:
// action bit layout, container type encodings and PHV block offsets.
package sub_deparser_pkg;

   localparam int ACT_VALID_BIT = 0;
   localparam int ACT_IDX_LSB   = 1;
   localparam int ACT_TYPE_LSB  = 4;
   localparam int ACT_TYPE_W    = 2;
   localparam int ACT_OFF_LSB   = 6;
   localparam int ACT_OFF_W     = 7;

   localparam int W_2B    = 16;
   localparam int W_4B    = 32;
   localparam int W_6B    = 48;
   localparam int FIELD_W = 48;

   typedef enum logic [1:0] {
      SEL_NONE = 2'b00,
      SEL_2B   = 2'b01,
      SEL_4B   = 2'b10,
      SEL_6B   = 2'b11
   } sel_e;

   // The 2B block sits at bit 0, the 4B block follows it, then the 6B block.
   function automatic int base_4b(input int num_2b);
      return num_2b * W_2B;
   endfunction

   function automatic int base_6b(input int num_2b, input int num_4b);
      return num_2b * W_2B + num_4b * W_4B;
   endfunction

endpackage

// File: rtl/phv_container_mux.sv
// Combinational container picker: returns one PHV container zero-extended
// to 48 bits, or zero with out_of_range set when the index is past the
// number of containers of that type.
module phv_container_mux
   import sub_deparser_pkg::*;
#(
   parameter int C_NUM_2B    = 8,
   parameter int C_NUM_4B    = 8,
   parameter int C_NUM_6B    = 8,
   parameter int C_IDX_WIDTH = 3,
   parameter int C_PHV_WIDTH = 16*C_NUM_2B + 32*C_NUM_4B + 48*C_NUM_6B
) (
   input  logic [C_PHV_WIDTH-1:0] phv,
   input  logic [1:0]             sel,
   input  logic [C_IDX_WIDTH-1:0] idx,
   output logic [FIELD_W-1:0]     data,
   output logic                   out_of_range
);

   localparam int B4 = base_4b(C_NUM_2B);
   localparam int B6 = base_6b(C_NUM_2B, C_NUM_4B);

   // Index compare per container keeps every select in range; no match leaves data at zero.
   always_comb begin
      data         = '0;
      out_of_range = 1'b0;
      case (sel)
         SEL_2B: begin
            out_of_range = (int'(idx) >= C_NUM_2B);
            for (int i = 0; i < C_NUM_2B; i++)
               if (int'(idx) == i) data[W_2B-1:0] = phv[i*W_2B +: W_2B];
         end
         SEL_4B: begin
            out_of_range = (int'(idx) >= C_NUM_4B);
            for (int i = 0; i < C_NUM_4B; i++)
               if (int'(idx) == i) data[W_4B-1:0] = phv[B4 + i*W_4B +: W_4B];
         end
         SEL_6B: begin
            out_of_range = (int'(idx) >= C_NUM_6B);
            for (int i = 0; i < C_NUM_6B; i++)
               if (int'(idx) == i) data[W_6B-1:0] = phv[B6 + i*W_6B +: W_6B];
         end
         default: begin
            data         = '0;
            out_of_range = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/sub_deparser_seq.sv
// Sequential deparser field extractor. Latches one packet's PHV and action
// vector, then emits one container per live action on a valid/ready stream.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   S_IDLE | in_ready high; a handshake loads the first live field directly
//   S_RUN  | walking the remaining live actions, one field per acceptance
module sub_deparser_seq
   import sub_deparser_pkg::*;
#(
   parameter int C_NUM_2B       = 8,
   parameter int C_NUM_4B       = 8,
   parameter int C_NUM_6B       = 8,
   parameter int C_IDX_WIDTH    = 3,
   parameter int C_NUM_ACTIONS  = 10,
   parameter int C_ACTION_WIDTH = 16,
   parameter int C_PHV_WIDTH    = 16*C_NUM_2B + 32*C_NUM_4B + 48*C_NUM_6B
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic [C_PHV_WIDTH-1:0]                  phv_in,
   input  logic [C_NUM_ACTIONS*C_ACTION_WIDTH-1:0] actions_in,
   input  logic                                    in_valid,
   output logic                                    in_ready,
   output logic [FIELD_W-1:0]                      field_data,
   output logic [1:0]                              field_select,
   output logic [ACT_OFF_W-1:0]                    field_offset,
   output logic                                    field_last,
   output logic                                    field_valid,
   input  logic                                    field_ready,
   output logic                                    done,
   output logic                                    range_err
);

   localparam int AW = C_NUM_ACTIONS * C_ACTION_WIDTH;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_e;

   state_e                   state;
   logic [C_PHV_WIDTH-1:0]   phv_q;
   logic [AW-1:0]            act_q;
   logic [C_NUM_ACTIONS-1:0] live_q;
   logic                     done_empty_q;

   logic                     idle;
   logic [C_PHV_WIDTH-1:0]   cur_phv;
   logic [AW-1:0]            cur_act;
   logic [C_NUM_ACTIONS-1:0] live_in;
   logic [C_NUM_ACTIONS-1:0] cur_live;
   logic [C_NUM_ACTIONS-1:0] first_oh;
   logic [C_NUM_ACTIONS-1:0] rest_live;
   logic [ACT_TYPE_W-1:0]    act_type;
   logic [C_IDX_WIDTH-1:0]   act_idx;
   logic [ACT_OFF_W-1:0]     act_off;
   logic [FIELD_W-1:0]       mux_data;
   logic                     mux_oor;
   logic                     accept_last;
   logic                     unused_act_bits;

   // In IDLE the first field is picked straight from the inputs so it appears one cycle after the handshake.
   assign idle    = (state == S_IDLE);
   assign cur_phv = idle ? phv_in : phv_q;
   assign cur_act = idle ? actions_in : act_q;

   // Offset and ignored high bits of each action are carried but only partly consumed.
   assign unused_act_bits = ^cur_act;

   // Live mask of the incoming action vector: valid bit set and a real container type.
   always_comb begin
      live_in = '0;
      for (int k = 0; k < C_NUM_ACTIONS; k++)
         live_in[k] = actions_in[k*C_ACTION_WIDTH + ACT_VALID_BIT] &
                      (actions_in[k*C_ACTION_WIDTH + ACT_TYPE_LSB +: ACT_TYPE_W] != 2'b00);
   end

   // Lowest remaining live action wins; skipped actions never cost a cycle.
   assign cur_live  = idle ? live_in : live_q;
   assign first_oh  = cur_live & (~cur_live + {{(C_NUM_ACTIONS-1){1'b0}}, 1'b1});
   assign rest_live = cur_live & ~first_oh;

   // Pull the type, index and offset fields of the selected action.
   always_comb begin
      act_type = '0;
      act_idx  = '0;
      act_off  = '0;
      for (int k = 0; k < C_NUM_ACTIONS; k++) begin
         if (first_oh[k]) begin
            act_type = cur_act[k*C_ACTION_WIDTH + ACT_TYPE_LSB +: ACT_TYPE_W];
            act_idx  = cur_act[k*C_ACTION_WIDTH + ACT_IDX_LSB  +: C_IDX_WIDTH];
            act_off  = cur_act[k*C_ACTION_WIDTH + ACT_OFF_LSB  +: ACT_OFF_W];
         end
      end
   end

   phv_container_mux #(
      .C_NUM_2B    (C_NUM_2B),
      .C_NUM_4B    (C_NUM_4B),
      .C_NUM_6B    (C_NUM_6B),
      .C_IDX_WIDTH (C_IDX_WIDTH),
      .C_PHV_WIDTH (C_PHV_WIDTH)
   ) u_mux (
      .phv          (cur_phv),
      .sel          (act_type),
      .idx          (act_idx),
      .data         (mux_data),
      .out_of_range (mux_oor)
   );

   // done fires in the same cycle the final field is taken, or one cycle after an empty packet.
   assign accept_last = (state == S_RUN) && field_valid && field_ready && field_last;
   assign done        = !rst && (done_empty_q || accept_last);
   assign in_ready    = !rst && idle;

   // Packet FSM, pointer/live-mask bookkeeping and the output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         phv_q        <= '0;
         act_q        <= '0;
         live_q       <= '0;
         done_empty_q <= 1'b0;
         field_data   <= '0;
         field_select <= '0;
         field_offset <= '0;
         field_last   <= 1'b0;
         field_valid  <= 1'b0;
         range_err    <= 1'b0;
      end else begin
         done_empty_q <= 1'b0;
         range_err    <= 1'b0;
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  phv_q <= phv_in;
                  act_q <= actions_in;
                  if (live_in == '0) begin
                     done_empty_q <= 1'b1;
                  end else begin
                     field_valid  <= 1'b1;
                     field_data   <= mux_data;
                     field_select <= act_type;
                     field_offset <= act_off;
                     field_last   <= (rest_live == '0);
                     range_err    <= mux_oor;
                     live_q       <= rest_live;
                     state        <= S_RUN;
                  end
               end
            end
            S_RUN: begin
               if (accept_last) begin
                  field_valid <= 1'b0;
                  state       <= S_IDLE;
               end else if ((live_q != '0) && (!field_valid || field_ready)) begin
                  field_valid  <= 1'b1;
                  field_data   <= mux_data;
                  field_select <= act_type;
                  field_offset <= act_off;
                  field_last   <= (rest_live == '0);
                  range_err    <= mux_oor;
                  live_q       <= rest_live;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_deparser_seq.sv
// Directed bench for sub_deparser_seq: single field, multi-field walk with
// skipped actions, stall, empty packets, range error and mid-packet reset.
module tb_sub_deparser_seq;

   localparam int NA   = 10;
   localparam int AWID = 16;
   localparam int PW   = 16*8 + 32*8 + 48*8;
   localparam int PW_R = 16*8 + 32*6 + 48*8;

   logic              clk = 1'b0;
   logic              rst;
   logic [PW-1:0]     phv;
   logic [PW_R-1:0]   phv_r;
   logic [NA*AWID-1:0] actions;
   logic              in_valid;
   logic              field_ready;

   logic              in_ready, field_last, field_valid, done, range_err;
   logic [47:0]       field_data;
   logic [1:0]        field_select;
   logic [6:0]        field_offset;

   logic              in_ready_r, field_last_r, field_valid_r, done_r, range_err_r;
   logic [47:0]       field_data_r;
   logic [1:0]        field_select_r;
   logic [6:0]        field_offset_r;

   int n_checks = 0;
   int n_fail   = 0;

   assign phv_r = phv[PW_R-1:0];

   always #5 clk = ~clk;

   sub_deparser_seq u_dut (
      .clk          (clk),
      .rst          (rst),
      .phv_in       (phv),
      .actions_in   (actions),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .field_data   (field_data),
      .field_select (field_select),
      .field_offset (field_offset),
      .field_last   (field_last),
      .field_valid  (field_valid),
      .field_ready  (field_ready),
      .done         (done),
      .range_err    (range_err)
   );

   sub_deparser_seq #(.C_NUM_4B(6)) u_dut_r (
      .clk          (clk),
      .rst          (rst),
      .phv_in       (phv_r),
      .actions_in   (actions),
      .in_valid     (in_valid),
      .in_ready     (in_ready_r),
      .field_data   (field_data_r),
      .field_select (field_select_r),
      .field_offset (field_offset_r),
      .field_last   (field_last_r),
      .field_valid  (field_valid_r),
      .field_ready  (field_ready),
      .done         (done_r),
      .range_err    (range_err_r)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_field(input string tag, input logic [47:0] d, input logic [1:0] s,
                            input logic [6:0] o, input logic l);
      chk({tag, "_valid"},  field_valid,  1'b1);
      chk({tag, "_data"},   field_data,   d);
      chk({tag, "_select"}, field_select, s);
      chk({tag, "_offset"}, field_offset, o);
      chk({tag, "_last"},   field_last,   l);
   endtask

   task automatic clear_pkt();
      phv     = '0;
      actions = '0;
   endtask

   task automatic set_act(input int k, input logic v, input logic [2:0] idx,
                          input logic [1:0] ty, input logic [6:0] off);
      actions[k*AWID +: AWID] = {3'b000, off, ty, idx, v};
   endtask

   task automatic pkt_single();
      clear_pkt();
      phv[3*16 +: 16] = 16'hABCD;
      set_act(0, 1'b1, 3'd3, 2'b01, 7'd14);
   endtask

   task automatic pkt_three();
      clear_pkt();
      phv[0*16 +: 16]        = 16'h1234;
      phv[128 + 7*32 +: 32]  = 32'hDEADBEEF;
      phv[384 + 2*48 +: 48]  = 48'h0123456789AB;
      set_act(0, 1'b1, 3'd0, 2'b01, 7'd2);
      set_act(1, 1'b0, 3'd3, 2'b10, 7'd5);
      set_act(2, 1'b1, 3'd1, 2'b00, 7'd9);
      set_act(4, 1'b1, 3'd7, 2'b10, 7'd10);
      set_act(9, 1'b1, 3'd2, 2'b11, 7'd20);
   endtask

   // Waits a bounded time for in_ready, then performs one input handshake.
   task automatic send();
      int t;
      t = 0;
      while (!in_ready && t < 20) begin
         step();
         t++;
      end
      chk("in_ready_wait", in_ready, 1'b1);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      field_ready = 1'b1;
      clear_pkt();
      repeat (3) step();

      chk("rst_in_ready",    in_ready,    1'b0);
      chk("rst_field_valid", field_valid, 1'b0);
      chk("rst_field_data",  field_data,  48'h0);
      chk("rst_done",        done,        1'b0);
      chk("rst_range_err",   range_err,   1'b0);
      rst = 1'b0;
      step();
      chk("idle_in_ready", in_ready, 1'b1);

      // single 2B field
      pkt_single();
      send();
      chk_field("single", 48'h00000000ABCD, 2'b01, 7'd14, 1'b1);
      chk("single_done", done, 1'b1);
      step();
      chk("single_valid_drop", field_valid, 1'b0);
      chk("single_done_drop",  done,        1'b0);
      chk("single_in_ready",   in_ready,    1'b1);

      // three live actions among skipped ones, ready held high; also range check on 4B-count-6 instance
      pkt_three();
      send();
      chk_field("three_f0", 48'h000000001234, 2'b01, 7'd2, 1'b0);
      chk("three_f0_done", done, 1'b0);
      step();
      chk_field("three_f1", 48'h0000DEADBEEF, 2'b10, 7'd10, 1'b0);
      chk("three_f1_done",   done,         1'b0);
      chk("three_f1_rerr",   range_err,    1'b0);
      chk("rng_valid",       field_valid_r, 1'b1);
      chk("rng_data",        field_data_r,  48'h0);
      chk("rng_err",         range_err_r,   1'b1);
      step();
      chk_field("three_f2", 48'h0123456789AB, 2'b11, 7'd20, 1'b1);
      chk("three_f2_done", done,        1'b1);
      chk("rng_err_once",  range_err_r, 1'b0);
      step();
      chk("three_valid_drop", field_valid, 1'b0);
      chk("three_in_ready",   in_ready,    1'b1);

      // same packet with a four-cycle stall on the second field
      pkt_three();
      send();
      chk_field("stall_f0", 48'h000000001234, 2'b01, 7'd2, 1'b0);
      step();
      chk_field("stall_f1", 48'h0000DEADBEEF, 2'b10, 7'd10, 1'b0);
      field_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk_field("stall_hold", 48'h0000DEADBEEF, 2'b10, 7'd10, 1'b0);
         chk("stall_hold_done", done, 1'b0);
      end
      field_ready = 1'b1;
      step();
      chk_field("stall_f2", 48'h0123456789AB, 2'b11, 7'd20, 1'b1);
      chk("stall_f2_done", done, 1'b1);
      step();
      chk("stall_valid_drop", field_valid, 1'b0);

      // all actions invalid
      clear_pkt();
      send();
      chk("empty_valid", field_valid, 1'b0);
      chk("empty_done",  done,        1'b1);
      step();
      chk("empty_done_drop", done,        1'b0);
      chk("empty_valid2",    field_valid, 1'b0);

      // valid bit with type 00, and a typed action without valid bit
      clear_pkt();
      set_act(3, 1'b1, 3'd2, 2'b00, 7'd33);
      set_act(5, 1'b0, 3'd1, 2'b10, 7'd44);
      send();
      chk("nolive_valid", field_valid, 1'b0);
      chk("nolive_done",  done,        1'b1);
      step();
      chk("nolive_done_drop", done, 1'b0);

      // reset after the first of three fields
      pkt_three();
      send();
      chk_field("rst_f0", 48'h000000001234, 2'b01, 7'd2, 1'b0);
      rst = 1'b1;
      step();
      chk("midrst_valid",    field_valid, 1'b0);
      chk("midrst_done",     done,        1'b0);
      chk("midrst_in_ready", in_ready,    1'b0);
      rst = 1'b0;
      step();
      chk("postrst_in_ready", in_ready,    1'b1);
      chk("postrst_valid",    field_valid, 1'b0);
      chk("postrst_done",     done,        1'b0);
      pkt_single();
      send();
      chk_field("postrst", 48'h00000000ABCD, 2'b01, 7'd14, 1'b1);
      chk("postrst_pkt_done", done, 1'b1);
      step();
      chk("postrst_end_valid", field_valid, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
